// File: rtl/llc_in_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : llc_in_arbiter_if
// Description : Handshake bundle between the three LLC inbound channels, the
//               LLC input arbiter and the LLC core input port.
// Revision    : 1.0 - initial release
// ============================================================================
interface llc_in_arbiter_if #(
    parameter int RSP_W = 128,
    parameter int REQ_W = 160
);
    logic               rsp_in_valid;
    logic               rsp_in_ready;
    logic [RSP_W-1:0]   rsp_in_data;
    logic               req_in_valid;
    logic               req_in_ready;
    logic [REQ_W-1:0]   req_in_data;
    logic               dma_req_in_valid;
    logic               dma_req_in_ready;
    logic [REQ_W-1:0]   dma_req_in_data;
    logic               dma_req_in_last;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_src;
    logic [REQ_W-1:0]   out_data;

    // Sources and the LLC core side
    modport master (
        output rsp_in_valid, rsp_in_data,
        output req_in_valid, req_in_data,
        output dma_req_in_valid, dma_req_in_data, dma_req_in_last,
        output out_ready,
        input  rsp_in_ready, req_in_ready, dma_req_in_ready,
        input  out_valid, out_src, out_data
    );

    // Arbiter side
    modport slave (
        input  rsp_in_valid, rsp_in_data,
        input  req_in_valid, req_in_data,
        input  dma_req_in_valid, dma_req_in_data, dma_req_in_last,
        input  out_ready,
        output rsp_in_ready, req_in_ready, dma_req_in_ready,
        output out_valid, out_src, out_data
    );
endinterface
`default_nettype wire

// File: rtl/llc_in_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : llc_in_arbiter
// Description : Merges rsp/req/dma inbound channels into one registered stream;
//               rsp priority with starvation cap, req/dma round-robin, atomic
//               DMA bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module llc_in_arbiter #(
    parameter int RSP_W   = 128,
    parameter int REQ_W   = 160,
    parameter int RSP_MAX = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    llc_in_arbiter_if.slave     bus
);
    localparam int               c_CNT_W   = $clog2(RSP_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_RSP_MAX = c_CNT_W'(RSP_MAX);
    localparam logic [1:0]       c_SRC_RSP = 2'd0;
    localparam logic [1:0]       c_SRC_REQ = 2'd1;
    localparam logic [1:0]       c_SRC_DMA = 2'd2;

    typedef enum logic [0:0] {
        S_OPEN     = 1'b0,
        S_DMA_LOCK = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_rsp_cnt;
    logic               r_rr_ptr;
    logic               r_out_valid;
    logic [1:0]         r_out_src;
    logic [REQ_W-1:0]   r_out_data;

    logic w_can_load;
    logic w_req_elig;
    logic w_dma_elig;
    logic w_any_req;
    logic w_capped;
    logic w_gnt_rsp;
    logic w_gnt_req;
    logic w_gnt_dma;

    always_comb begin
        w_can_load = !r_out_valid || bus.out_ready;
        w_req_elig = bus.req_in_valid && (r_state == S_OPEN);
        w_dma_elig = bus.dma_req_in_valid;
        w_any_req  = w_req_elig || w_dma_elig;
        w_capped   = (r_rsp_cnt == c_RSP_MAX) && w_any_req;
        w_gnt_rsp  = !rst && w_can_load && bus.rsp_in_valid && !w_capped;
        w_gnt_req  = 1'b0;
        w_gnt_dma  = 1'b0;
        // req is already masked off during a burst, so only dma can win then
        if (!rst && w_can_load && !w_gnt_rsp) begin
            if (r_rr_ptr) begin
                w_gnt_dma = w_dma_elig;
                w_gnt_req = !w_dma_elig && w_req_elig;
            end else begin
                w_gnt_req = w_req_elig;
                w_gnt_dma = !w_req_elig && w_dma_elig;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_OPEN;
            r_rsp_cnt   <= '0;
            r_rr_ptr    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_src   <= c_SRC_RSP;
            r_out_data  <= '0;
        end else begin
            if (w_can_load) begin
                r_out_valid <= w_gnt_rsp || w_gnt_req || w_gnt_dma;
                if (w_gnt_rsp) begin
                    r_out_src  <= c_SRC_RSP;
                    r_out_data <= REQ_W'(bus.rsp_in_data);
                end else if (w_gnt_req) begin
                    r_out_src  <= c_SRC_REQ;
                    r_out_data <= bus.req_in_data;
                end else if (w_gnt_dma) begin
                    r_out_src  <= c_SRC_DMA;
                    r_out_data <= bus.dma_req_in_data;
                end
            end

            // Stalled burst with no dma beat: keep the count so the cap resumes
            if (w_gnt_req || w_gnt_dma) begin
                r_rsp_cnt <= '0;
            end else if (w_gnt_rsp && w_any_req) begin
                if (r_rsp_cnt != c_RSP_MAX) begin
                    r_rsp_cnt <= r_rsp_cnt + c_CNT_W'(1);
                end
            end else if (!w_any_req && (r_state == S_OPEN)) begin
                r_rsp_cnt <= '0;
            end

            if (w_gnt_req) begin
                r_rr_ptr <= 1'b1;
            end else if (w_gnt_dma && bus.dma_req_in_last) begin
                r_rr_ptr <= 1'b0;
            end

            if (w_gnt_dma) begin
                r_state <= bus.dma_req_in_last ? S_OPEN : S_DMA_LOCK;
            end
        end
    end

    assign bus.rsp_in_ready     = w_gnt_rsp;
    assign bus.req_in_ready     = w_gnt_req;
    assign bus.dma_req_in_ready = w_gnt_dma;
    assign bus.out_valid        = r_out_valid;
    assign bus.out_src          = r_out_src;
    assign bus.out_data         = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_llc_in_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_llc_in_arbiter
// Description : Directed and randomized checks of llc_in_arbiter against a
//               behavioural grant model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llc_in_arbiter;
    localparam int RSP_W   = 128;
    localparam int REQ_W   = 160;
    localparam int RSP_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    llc_in_arbiter_if #(.RSP_W(RSP_W), .REQ_W(REQ_W)) bus ();

    llc_in_arbiter #(.RSP_W(RSP_W), .REQ_W(REQ_W), .RSP_MAX(RSP_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: counts of consecutive rsp wins, who is favoured next,
    // whether a DMA burst owns the request side, and the output register.
    int               m_streak;
    int               m_favour;
    bit               m_burst;
    bit               m_ov;
    int               m_src;
    logic [REQ_W-1:0] m_data;

    // Grant of the last step (-1 none, 0 rsp, 1 req, 2 dma) and acceptance flags
    int g_gnt;
    bit g_acc_rsp, g_acc_req, g_acc_dma;

    task automatic check(input string tag, input logic [REQ_W-1:0] obs, input logic [REQ_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] rnd_word();
        logic [REQ_W-1:0] v;
        for (int i = 0; i < REQ_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit src_valid(input int s);
        if (s == 1) return bus.req_in_valid;
        return bus.dma_req_in_valid;
    endfunction

    // Which request source would win if rsp stepped aside
    function automatic int request_winner();
        int order[2];
        if (m_burst) return bus.dma_req_in_valid ? 2 : -1;
        order[0] = (m_favour == 1) ? 1 : 2;
        order[1] = 3 - order[0];
        foreach (order[k]) if (src_valid(order[k])) return order[k];
        return -1;
    endfunction

    task automatic set_in(input bit rv, input bit qv, input bit dv, input bit dl, input bit ordy);
        bus.rsp_in_valid     = rv;
        bus.rsp_in_data      = RSP_W'(rnd_word());
        bus.req_in_valid     = qv;
        bus.req_in_data      = rnd_word();
        bus.dma_req_in_valid = dv;
        bus.dma_req_in_data  = rnd_word();
        bus.dma_req_in_last  = dl;
        bus.out_ready        = ordy;
    endtask

    // One clock: check readys against the model, clock, then check the output register
    task automatic step();
        int  win, gnt;
        bit  can, rsp_wins, in_rst, last;
        logic [REQ_W-1:0] rsp_d, req_d, dma_d;
        #1;
        in_rst   = rst;
        last     = bus.dma_req_in_last;
        rsp_d    = REQ_W'(bus.rsp_in_data);
        req_d    = bus.req_in_data;
        dma_d    = bus.dma_req_in_data;
        can      = !m_ov || bus.out_ready;
        win      = request_winner();
        rsp_wins = bus.rsp_in_valid && !(m_streak == RSP_MAX && win != -1);
        gnt      = -1;
        if (can && !in_rst) gnt = rsp_wins ? 0 : win;
        check("rsp_in_ready", REQ_W'(bus.rsp_in_ready), REQ_W'(gnt == 0));
        check("req_in_ready", REQ_W'(bus.req_in_ready), REQ_W'(gnt == 1));
        check("dma_req_in_ready", REQ_W'(bus.dma_req_in_ready), REQ_W'(gnt == 2));
        g_gnt     = gnt;
        g_acc_rsp = (gnt == 0);
        g_acc_req = (gnt == 1);
        g_acc_dma = (gnt == 2);
        @(posedge clk);
        if (in_rst) begin
            m_streak = 0; m_favour = 1; m_burst = 0;
            m_ov = 0; m_src = 0; m_data = '0;
        end else begin
            if (gnt == 1) begin
                m_favour = 2; m_streak = 0;
            end else if (gnt == 2) begin
                m_streak = 0;
                m_burst  = !last;
                if (last) m_favour = 1;
            end else if (gnt == 0 && win != -1) begin
                m_streak = (m_streak < RSP_MAX) ? m_streak + 1 : RSP_MAX;
            end else if (win == -1 && !m_burst) begin
                m_streak = 0;
            end
            if (can) begin
                m_ov = (gnt != -1);
                case (gnt)
                    0: begin m_src = 0; m_data = rsp_d; end
                    1: begin m_src = 1; m_data = req_d; end
                    2: begin m_src = 2; m_data = dma_d; end
                    default: ;
                endcase
            end
        end
        #1;
        check("out_valid", REQ_W'(bus.out_valid), REQ_W'(m_ov));
        check("out_src", REQ_W'(bus.out_src), REQ_W'(m_src));
        check("out_data", bus.out_data, m_data);
    endtask

    task automatic reset_step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int exp_seq[15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1};
        bit rv, qv, dv, dl;

        m_streak = 0; m_favour = 1; m_burst = 0; m_ov = 0; m_src = 0; m_data = '0;
        rst = 1'b1;
        set_in(1, 1, 1, 0, 1);
        step();
        step();
        rst = 1'b0;

        // req only, three beats back to back
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 0, 1, 1);
            step();
            check("req_stream_src", REQ_W'(bus.out_src), REQ_W'(1));
        end
        set_in(0, 0, 0, 1, 1);
        step();

        // all three continuously valid: rsp x4, then alternate req/dma
        reset_step();
        for (int i = 0; i < 15; i++) begin
            set_in(1, 1, 1, 1, 1);
            step();
            check("cap_sequence", REQ_W'(bus.out_src), REQ_W'(exp_seq[i]));
        end

        // DMA burst of three beats holds off req
        set_in(0, 1, 1, 0, 1); step();
        set_in(0, 1, 1, 0, 1); step();
        set_in(0, 1, 1, 1, 1); step();
        set_in(0, 1, 0, 1, 1); step();
        check("req_after_burst", REQ_W'(bus.out_src), REQ_W'(1));
        set_in(0, 0, 0, 1, 1); step();

        // output backpressure with everything valid
        for (int i = 0; i < 4; i++) begin set_in(1, 1, 1, 1, 0); step(); end
        for (int i = 0; i < 4; i++) begin set_in(1, 1, 1, 1, 1); step(); end

        // reset in the middle of a burst
        set_in(0, 0, 1, 0, 1); step();
        set_in(0, 0, 1, 0, 0); step();
        set_in(1, 1, 1, 0, 0);
        reset_step();
        set_in(0, 1, 1, 1, 1); step();
        check("req_first_after_rst", REQ_W'(bus.out_src), REQ_W'(1));

        // rsp only for ten beats, then the cap must still allow four rsp
        for (int i = 0; i < 10; i++) begin set_in(1, 0, 0, 1, 1); step(); end
        for (int i = 0; i < 6; i++) begin set_in(1, 1, 1, 1, 1); step(); end

        // randomized traffic honouring hold-until-accepted
        set_in(0, 0, 0, 1, 1);
        for (int i = 0; i < 3000; i++) begin
            rv = bus.rsp_in_valid && !g_acc_rsp;
            qv = bus.req_in_valid && !g_acc_req;
            dv = bus.dma_req_in_valid && !g_acc_dma;
            if (!rv) begin
                bus.rsp_in_valid = ($urandom_range(0, 2) != 0);
                bus.rsp_in_data  = RSP_W'(rnd_word());
            end
            if (!qv) begin
                bus.req_in_valid = ($urandom_range(0, 2) != 0);
                bus.req_in_data  = rnd_word();
            end
            if (!dv) begin
                bus.dma_req_in_valid = ($urandom_range(0, 2) != 0);
                bus.dma_req_in_data  = rnd_word();
                dl = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
                bus.dma_req_in_last  = dl;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) reset_step();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/llc_in_arbiter.md
Name: llc_in_arbiter

Overview:
- Front-end arbiter for the LLC.
- Merges three inbound channels into one registered stream that feeds the LLC core's single input port:
  - coherence responses (rsp_in),
  - CPU-side coherence requests (req_in),
  - DMA requests (dma_req_in).
- Priority rule: responses always win, with a starvation cap.
- Fairness rule: requests and DMA share round-robin, except that a DMA write burst is atomic with respect to req_in.

Parameters:
- RSP_W, 128, packed response payload width (coh_msg, addr, line, req_id).
- REQ_W, 160, packed request payload width (coh_msg, hprot, addr, line, req_id, word_offset, valid_words); req_in and dma_req_in share it.
- RSP_MAX, 4, maximum consecutive rsp grants while any request is pending.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rsp_in_valid  in  1  response available
- rsp_in_ready  out  1  response accepted this cycle
- rsp_in_data  in  RSP_W  response payload
- req_in_valid  in  1  coherence request available
- req_in_ready  out  1  request accepted
- req_in_data  in  REQ_W  request payload
- dma_req_in_valid  in  1  DMA request available
- dma_req_in_ready  out  1  DMA request accepted
- dma_req_in_data  in  REQ_W  DMA payload
- dma_req_in_last  in  1  last beat of DMA burst (1 for single-beat requests)
- out_valid  out  1  output register holds a message
- out_ready  in  1  LLC core accepts the output
- out_src  out  2  source: 0 = rsp, 1 = req, 2 = dma
- out_data  out  REQ_W  payload; rsp payload is zero-extended in the LSBs

Behaviour:
- Handshakes:
  - Each channel transfers on valid && ready.
  - Valid must hold with stable data until accepted. The block does not check this.
- Output stage: a single register.
  - can_load = !out_valid || out_ready.
  - A grant occurs only when can_load.
  - The granted input's ready is high in the same cycle, combinationally from its valid and the arbiter state.
  - The output register loads on the next clk edge. Latency from input accept to out_valid is 1 cycle.
  - When can_load is true and no input is granted, out_valid clears at the edge if out_ready was high.
  - Throughput is 1 message per cycle under continuous out_ready.
- At most one ready is asserted per cycle. No ready may be asserted while !can_load.
- Grant order, evaluated each cycle:
  1. rsp, if rsp_in_valid and not capped.
  2. Cap: rsp_cnt == RSP_MAX and (req_in_valid or dma_req_in_valid, after lock masking) -> rsp is skipped for this cycle.
  3. Among requests: if dma_lock, only dma is eligible.
  4. Otherwise round-robin via rr_ptr (0 favours req, 1 favours dma). The favoured source is granted if valid, else the other.
- rsp_cnt (width clog2(RSP_MAX+1)):
  - Increments on an rsp grant while any eligible request is valid.
  - Saturates at RSP_MAX.
  - Clears on any request grant, or when no request is pending.
- rr_ptr:
  - After a req grant -> 1.
  - After a dma grant with last=1 -> 0.
  - A dma grant with last=0 leaves rr_ptr unchanged.
- dma_lock:
  - Set on a dma grant with dma_req_in_last=0.
  - Cleared on a dma grant with last=1.
  - While set: req_in_ready=0. rsp still flows, subject to the cap.
  - While set with dma_req_in_valid=0: no request is granted, and the rsp cap is not enforced (rsp_cnt holds at its value).
- Reset (synchronous, any time including mid-burst):
  - out_valid=0, out_src=0, out_data=0, rsp_cnt=0, rr_ptr=0, dma_lock=0.
  - All readys are 0 during the reset cycle.
  - A burst in progress is abandoned without error.
- Simultaneous events:
  - out_ready and a new grant in the same cycle: the register is replaced, with no bubble.
  - All three inputs valid with rsp_cnt < RSP_MAX: rsp is granted.

Test Plan:
- Only req_in_valid=1 for 3 beats, out_ready=1 -> req_in_ready high 3 cycles; out_valid high cycles 1-3, out_src=1, data in order.
- rsp, req and dma all continuously valid, RSP_MAX=4, out_ready=1 -> grant sequence rsp×4, req, rsp×4, dma, rsp×4, req …
- req and dma valid, no rsp; dma beats last=0,0,1 -> grants dma, dma, dma, then req. req_in_ready=0 for the first 3 cycles.
- out_ready=0 with out_valid=1 and all inputs valid -> all readys 0; out_data stable until out_ready rises. Then exactly one new grant per cycle.
- rst asserted for 1 cycle during dma_lock=1 with out_valid=1 -> next cycle out_valid=0, dma_lock=0. Afterward req_in is granted first when req and dma are both valid (rr_ptr=0).
- rsp only, 10 beats, req idle -> 10 consecutive rsp grants with no cap stall; rsp_cnt stays 0.
